// File: rtl/mrd_inv_ctrl.sv
// ---------------------------------------------------------------------------
// mrd_inv_ctrl
//
// Sequencing controller for the MRD approximate-inverse iteration datapath.
// It is the only source of the datapath mux selects and capture/load strobes.
// Each accepted start walks the M2V / V2V pipeline through a fixed number of
// iterations and then pulses done for one cycle.
//
// Parameters
//   ITER_NUM  iterations per run (0 behaves as 1)
//   MV_LAT    M2V latency in cycles (>= 1)
//   VV_LAT    V2V dot-product latency in cycles (>= 1)
//   CNT_W     width of the wait counter and the iteration counter
//
// Ports
//   clk_i         single clock, rising edge
//   rst_ni        asynchronous active-low reset
//   en_i          global enable; low freezes state and counters
//   start_i       run request, only looked at while idle
//   abort_i       synchronous abort back to idle, no done pulse
//   busy_o        high whenever the controller is not idle
//   done_o        one-cycle completion pulse
//   slc_sig1_o    Mi mux select (0 = M_init, 1 = Mi_update)
//   slc_sig2_o    M2V input mux select (0 = Mi, 1 = rj)
//   mi_load_o     Mi register load strobe
//   rj_cap_o      rj = ej - MV capture strobe
//   alpha_cap_o   alpha capture strobe
//   iter_cnt_o    number of completed iterations
// ---------------------------------------------------------------------------
module mrd_inv_ctrl #(
    parameter int ITER_NUM = 2,
    parameter int MV_LAT   = 2,
    parameter int VV_LAT   = 1,
    parameter int CNT_W    = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             start_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             slc_sig1_o,
    output logic             slc_sig2_o,
    output logic             mi_load_o,
    output logic             rj_cap_o,
    output logic             alpha_cap_o,
    output logic [CNT_W-1:0] iter_cnt_o
);

    // A run always performs at least one iteration.
    localparam int               ITER_EFF  = (ITER_NUM < 1) ? 1 : ITER_NUM;
    localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(ITER_EFF);
    localparam logic [CNT_W-1:0] MV_LAST   = CNT_W'(MV_LAT - 1);
    localparam logic [CNT_W-1:0] VV_LAST   = CNT_W'(VV_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MV1,
        S_MV2,
        S_DOT,
        S_UPD,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_q,  wait_d;
    logic [CNT_W-1:0] iter_q,  iter_d;

    logic             mvLast;
    logic             vvLast;
    logic [CNT_W-1:0] iterInc;

    assign mvLast  = (wait_q == MV_LAST);
    assign vvLast  = (wait_q == VV_LAST);
    assign iterInc = iter_q + 1'b1;

    // State, wait counter and iteration counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            iter_q  <= iter_d;
        end
    end

    // Next-state logic. Abort outranks everything (including a low enable),
    // and a low enable freezes the sequence in place. The iteration counter
    // is cleared when a run is accepted and bumped on leaving UPD.
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        if (abort_i) begin
            state_d = S_IDLE;
        end else if (en_i) begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_d = S_LOAD;
                        iter_d  = '0;
                    end
                end
                S_LOAD: state_d = S_MV1;
                S_MV1: begin
                    if (mvLast) state_d = S_MV2;
                end
                S_MV2: begin
                    if (mvLast) state_d = S_DOT;
                end
                S_DOT: begin
                    if (vvLast) state_d = S_UPD;
                end
                S_UPD: begin
                    iter_d  = iterInc;
                    state_d = (iterInc == ITER_LAST) ? S_DONE : S_MV1;
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // The wait counter measures the cycle position inside the current state:
    // restart on any state change, otherwise advance only while enabled so
    // that a stall resumes at the same position.
    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q) begin
            wait_d = '0;
        end else if (en_i) begin
            wait_d = wait_q + 1'b1;
        end
    end

    // Moore output decode. Strobes and done are gated by the enable so a
    // frozen sequence never fires the datapath; the selects and busy follow
    // the state alone so the datapath muxes stay stable through a stall.
    always_comb begin
        busy_o      = 1'b0;
        done_o      = 1'b0;
        slc_sig1_o  = 1'b0;
        slc_sig2_o  = 1'b0;
        mi_load_o   = 1'b0;
        rj_cap_o    = 1'b0;
        alpha_cap_o = 1'b0;
        case (state_q)
            S_IDLE: begin
            end
            S_LOAD: begin
                busy_o    = 1'b1;
                mi_load_o = en_i;
            end
            S_MV1: begin
                busy_o   = 1'b1;
                rj_cap_o = en_i & mvLast;
            end
            S_MV2: begin
                busy_o     = 1'b1;
                slc_sig2_o = 1'b1;
            end
            S_DOT: begin
                busy_o      = 1'b1;
                slc_sig2_o  = 1'b1;
                alpha_cap_o = en_i & vvLast;
            end
            S_UPD: begin
                busy_o     = 1'b1;
                slc_sig1_o = 1'b1;
                mi_load_o  = en_i;
            end
            S_DONE: begin
                busy_o = 1'b1;
                done_o = en_i;
            end
            default: begin
            end
        endcase
    end

    assign iter_cnt_o = iter_q;

endmodule

// File: tb/tb_mrd_inv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mrd_inv_ctrl
//
// Two controller instances share one stimulus stream: the default
// configuration and a sweep configuration (ITER_NUM=0, MV_LAT=3, VV_LAT=2).
// A reference model tracks each run as a slot index inside the run
// (LOAD, N iterations of 2*MV+VV+1 slots, DONE) and derives the expected
// output word arithmetically. Expected words go into a per-instance queue;
// a monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_mrd_inv_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstN  = 1'b0;
    logic en    = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;

    logic       busy     [2];
    logic       done     [2];
    logic       sig1     [2];
    logic       sig2     [2];
    logic       miLoad   [2];
    logic       rjCap    [2];
    logic       alphaCap [2];
    logic [3:0] iterCnt  [2];

    mrd_inv_ctrl #(.ITER_NUM(2), .MV_LAT(2), .VV_LAT(1), .CNT_W(4)) dutA (
        .clk_i(clk), .rst_ni(rstN), .en_i(en), .start_i(start), .abort_i(abort),
        .busy_o(busy[0]), .done_o(done[0]), .slc_sig1_o(sig1[0]), .slc_sig2_o(sig2[0]),
        .mi_load_o(miLoad[0]), .rj_cap_o(rjCap[0]), .alpha_cap_o(alphaCap[0]),
        .iter_cnt_o(iterCnt[0])
    );

    mrd_inv_ctrl #(.ITER_NUM(0), .MV_LAT(3), .VV_LAT(2), .CNT_W(4)) dutB (
        .clk_i(clk), .rst_ni(rstN), .en_i(en), .start_i(start), .abort_i(abort),
        .busy_o(busy[1]), .done_o(done[1]), .slc_sig1_o(sig1[1]), .slc_sig2_o(sig2[1]),
        .mi_load_o(miLoad[1]), .rj_cap_o(rjCap[1]), .alpha_cap_o(alphaCap[1]),
        .iter_cnt_o(iterCnt[1])
    );

    // Reference model configuration per instance (effective iteration count).
    int mvL [2] = '{2, 3};
    int vvL [2] = '{1, 2};
    int itN [2] = '{2, 1};

    bit running [2];
    int pos     [2];
    int modelIt [2];

    logic [10:0] expQ0[$];
    logic [10:0] expQ1[$];

    int checks = 0;
    int errors = 0;
    int cycleNo = 0;

    // Expected output word {busy,done,sig1,sig2,mi,rj,alpha,iter[3:0]}.
    function automatic logic [10:0] expected(int k, bit enV);
        logic b, d, s1, s2, mi, rj, al;
        int runLen, p, ph, mv, vv;
        b = 0; d = 0; s1 = 0; s2 = 0; mi = 0; rj = 0; al = 0;
        mv = mvL[k];
        vv = vvL[k];
        runLen = 2 * mv + vv + 1;
        if (running[k]) begin
            b = 1;
            p = pos[k];
            if (p == 0) begin
                mi = enV;
            end else if (p == 1 + itN[k] * runLen) begin
                d = enV;
            end else begin
                ph = (p - 1) % runLen;
                if (ph < mv) begin
                    rj = enV && (ph == mv - 1);
                end else if (ph < 2 * mv) begin
                    s2 = 1;
                end else if (ph < 2 * mv + vv) begin
                    s2 = 1;
                    al = enV && (ph == 2 * mv + vv - 1);
                end else begin
                    s1 = 1;
                    mi = enV;
                end
            end
        end
        return {b, d, s1, s2, mi, rj, al, 4'(modelIt[k])};
    endfunction

    // Advance the model across one rising edge.
    task automatic modelEdge(int k, bit enV, bit startV, bit abortV);
        int runLen;
        runLen = 2 * mvL[k] + vvL[k] + 1;
        if (running[k] && abortV) begin
            running[k] = 0;
        end else if (enV) begin
            if (running[k]) begin
                if (pos[k] > 0 && pos[k] <= itN[k] * runLen && ((pos[k] - 1) % runLen) == runLen - 1)
                    modelIt[k]++;
                if (pos[k] == 1 + itN[k] * runLen) running[k] = 0;
                else pos[k]++;
            end else if (startV && !abortV) begin
                running[k] = 1;
                pos[k]     = 0;
                modelIt[k] = 0;
            end
        end
    endtask

    // Drive one cycle of inputs shortly after the rising edge, record what
    // both instances should show during this cycle, then step the model
    // across the coming edge.
    task automatic applyStimulus(bit rstV, bit enV, bit startV, bit abortV);
        @(posedge clk);
        #1;
        cycleNo++;
        rstN  = rstV;
        en    = enV;
        start = startV;
        abort = abortV;
        for (int k = 0; k < 2; k++) begin
            if (!rstV) begin
                running[k] = 0;
                pos[k]     = 0;
                modelIt[k] = 0;
            end
        end
        expQ0.push_back(expected(0, enV));
        expQ1.push_back(expected(1, enV));
        if (rstV) begin
            for (int k = 0; k < 2; k++) modelEdge(k, enV, startV, abortV);
        end
    endtask

    task automatic checkOutput(int k, logic [10:0] act, logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL out%0d cycle %0d: got busy/done/s1/s2/mi/rj/al=%b iter=%0d, want %b iter=%0d",
                     k, cycleNo, act[10:4], act[3:0], exp[10:4], exp[3:0]);
        end
    endtask

    // Monitor: one expected word per instance per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (expQ0.size() > 0)
            checkOutput(0, {busy[0], done[0], sig1[0], sig2[0], miLoad[0], rjCap[0], alphaCap[0], iterCnt[0]},
                        expQ0.pop_front());
        if (expQ1.size() > 0)
            checkOutput(1, {busy[1], done[1], sig1[1], sig2[1], miLoad[1], rjCap[1], alphaCap[1], iterCnt[1]},
                        expQ1.pop_front());
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            running[k] = 0;
            pos[k]     = 0;
            modelIt[k] = 0;
        end

        $display("[TB] reset hold with start toggling");
        for (int c = 0; c < 4; c++) applyStimulus(0, 1, c[0], 0);
        repeat (2) applyStimulus(1, 1, 0, 0);

        $display("[TB] nominal run");
        applyStimulus(1, 1, 1, 0);
        repeat (20) applyStimulus(1, 1, 0, 0);

        $display("[TB] enable stall in cycles 4-6");
        applyStimulus(1, 1, 1, 0);
        for (int c = 1; c <= 22; c++) applyStimulus(1, !(c >= 4 && c <= 6), 0, 0);

        $display("[TB] abort in cycle 9, then a fresh run");
        applyStimulus(1, 1, 1, 0);
        for (int c = 1; c <= 12; c++) applyStimulus(1, 1, 0, c == 9);
        applyStimulus(1, 1, 1, 0);
        repeat (20) applyStimulus(1, 1, 0, 0);

        $display("[TB] start and abort together while idle");
        applyStimulus(1, 1, 1, 1);
        repeat (3) applyStimulus(1, 1, 0, 0);

        $display("[TB] repeated start while busy");
        applyStimulus(1, 1, 1, 0);
        for (int c = 1; c <= 18; c++) applyStimulus(1, 1, (c % 3) == 0, 0);

        $display("[TB] asynchronous reset in cycle 5");
        applyStimulus(1, 1, 1, 0);
        for (int c = 1; c <= 4; c++) applyStimulus(1, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        repeat (20) applyStimulus(1, 1, 0, 0);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 800; c++)
            applyStimulus($urandom_range(0, 199) != 0, $urandom_range(0, 4) != 0,
                          $urandom_range(0, 5) == 0, $urandom_range(0, 39) == 0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
